// File: rtl/or_8way_if.sv
// Signal bundle for the reduction-OR detector: vector and clear in, OR result
// plus its registered companions out.
interface or_8way_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic [WIDTH-1:0] in;
  logic             clr;
  logic             out;
  logic             out_q;
  logic             sticky;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;

  modport master (
    output in, clr,
    input  out, out_q, sticky, idx, idx_valid
  );

  modport slave (
    input  in, clr,
    output out, out_q, sticky, idx, idx_valid
  );
endinterface

// File: rtl/or_8way.sv
// Reduction-OR leaf detector: combinational OR, a registered copy, a sticky
// any-seen flag, and the registered index of the lowest set bit.
module or_8way #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  or_8way_if.slave  bus
);

  // The tree is built over the next power of two; pad leaves are tied to 0.
  localparam int LEAVES = 1 << IDX_W;

  genvar l, k;
  generate
    for (l = 0; l <= IDX_W; l++) begin : g_lvl
      logic [(LEAVES >> l)-1:0] v;
      if (l == 0) begin : g_leaf
        for (k = 0; k < LEAVES; k++) begin : g_pad
          if (k < WIDTH) begin : g_real
            assign v[k] = bus.in[k];
          end else begin : g_zero
            assign v[k] = 1'b0;
          end
        end
      end else begin : g_node
        for (k = 0; k < (LEAVES >> l); k++) begin : g_or
          assign v[k] = g_lvl[l-1].v[2*k] | g_lvl[l-1].v[2*k+1];
        end
      end
    end
  endgenerate

  logic any_set;
  assign any_set = g_lvl[IDX_W].v[0];
  assign bus.out = any_set;

  // Lowest set bit wins: scanning downward lets lower indices overwrite.
  logic [IDX_W-1:0] low_idx;
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.in[i]) low_idx = IDX_W'(i);
    end
  end

  logic             out_dly_d, out_dly_q;
  logic             sticky_d, sticky_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             idx_valid_d, idx_valid_q;

  always_comb begin
    out_dly_d   = any_set;
    // Clear wins over hold, but a bit seen in the same cycle re-arms the flag.
    sticky_d    = bus.clr ? any_set : (sticky_q | any_set);
    idx_d       = any_set ? low_idx : idx_q;
    idx_valid_d = any_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dly_q   <= 1'b0;
      sticky_q    <= 1'b0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
    end else begin
      out_dly_q   <= out_dly_d;
      sticky_q    <= sticky_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
    end
  end

  assign bus.out_q     = out_dly_q;
  assign bus.sticky    = sticky_q;
  assign bus.idx       = idx_q;
  assign bus.idx_valid = idx_valid_q;

endmodule

// File: tb/tb_or_8way.sv
// Bench for or_8way: directed vector table, asynchronous reset sequence, and
// randomized traffic against a behavioural model.
module tb_or_8way;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic clk;
  logic rst_n;

  or_8way_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  or_8way #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WIDTH-1:0] in;
    logic             clr;
    logic             e_out;
    logic             e_out_q;
    logic             e_sticky;
    logic [IDX_W-1:0] e_idx;
    logic             e_valid;
  } vec_t;

  vec_t vecs[10];

  // Behavioural reference state.
  logic             m_sticky;
  logic [IDX_W-1:0] m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of lowest set bit from the isolated-LSB power of two.
  function automatic int lowest_bit(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] iso;
    iso = v & (~v + 1'b1);
    return $clog2(iso);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [WIDTH-1:0] v, input logic c);
    @(negedge clk);
    bus.in  = v;
    bus.clr = c;
    #1;
  endtask

  task automatic apply_vec(input vec_t t);
    drive(t.in, t.clr);
    check("out_comb", 32'(bus.out), 32'(t.e_out));
    @(posedge clk);
    #1;
    check("out_q",     32'(bus.out_q),     32'(t.e_out_q));
    check("sticky",    32'(bus.sticky),    32'(t.e_sticky));
    check("idx",       32'(bus.idx),       32'(t.e_idx));
    check("idx_valid", 32'(bus.idx_valid), 32'(t.e_valid));
  endtask

  task automatic apply_rand(input logic [WIDTH-1:0] v, input logic c);
    logic any;
    any = (v != '0);
    drive(v, c);
    check("rnd_out", 32'(bus.out), 32'(any));
    m_sticky = c ? any : (m_sticky | any);
    if (any) m_idx = IDX_W'(lowest_bit(v));
    @(posedge clk);
    #1;
    check("rnd_out_q",  32'(bus.out_q),     32'(any));
    check("rnd_sticky", 32'(bus.sticky),    32'(m_sticky));
    check("rnd_idx",    32'(bus.idx),       32'(m_idx));
    check("rnd_valid",  32'(bus.idx_valid), 32'(any));
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    int kind;

    //                in     clr  out q  stk idx val
    vecs[0] = '{8'hFF, 1'b0, 1, 1, 1, 3'd0, 1};
    vecs[1] = '{8'h00, 1'b0, 0, 0, 1, 3'd0, 0};
    vecs[2] = '{8'hAA, 1'b0, 1, 1, 1, 3'd1, 1};
    vecs[3] = '{8'h80, 1'b0, 1, 1, 1, 3'd7, 1};
    vecs[4] = '{8'h00, 1'b1, 0, 0, 0, 3'd7, 0};
    vecs[5] = '{8'h04, 1'b1, 1, 1, 1, 3'd2, 1};
    vecs[6] = '{8'h01, 1'b0, 1, 1, 1, 3'd0, 1};
    vecs[7] = '{8'h00, 1'b1, 0, 0, 0, 3'd0, 0};
    vecs[8] = '{8'h40, 1'b0, 1, 1, 1, 3'd6, 1};
    vecs[9] = '{8'h00, 1'b0, 0, 0, 1, 3'd6, 0};

    rst_n   = 1'b0;
    bus.in  = '0;
    bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_q",  32'(bus.out_q),     32'd0);
    check("rst_sticky", 32'(bus.sticky),    32'd0);
    check("rst_idx",    32'(bus.idx),       32'd0);
    check("rst_valid",  32'(bus.idx_valid), 32'd0);
    bus.in = 8'h10;
    #1;
    check("rst_out_follows", 32'(bus.out), 32'd1);
    @(negedge clk);
    bus.in = '0;
    rst_n  = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Mid-cycle asynchronous reset with all bits set.
    drive(8'hFF, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.idx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_q",  32'(bus.out_q),     32'd0);
    check("async_sticky", 32'(bus.sticky),    32'd0);
    check("async_idx",    32'(bus.idx),       32'd0);
    check("async_valid",  32'(bus.idx_valid), 32'd0);
    check("async_out",    32'(bus.out),       32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic from post-reset state.
    m_sticky = 1'b0;
    m_idx    = '0;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       rv = '0;
        1:       rv = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: rv = WIDTH'($urandom);
      endcase
      apply_rand(rv, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
